// File: rtl/time_disp_pkg.sv
// Shared types and constants for the time display engine.
//   state_e     : conversion FSM states
//   SEG_*       : segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-high
//   SEG_TABLE   : digit -> segment lookup, codes 10..15 render blank
//   bcd_adjust  : add-3 correction applied before each double-dabble shift
package time_disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    LOAD,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Entry 0 is the rightmost element.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

endpackage

// File: rtl/time_display_engine_bcd_to_ss7.sv
// Combinational BCD digit to seven-segment encoder.
//   digit : 4-bit digit code (10..15 render blank)
//   seg   : {dp,g,f,e,d,c,b,a}, active-high, dp always 0 here
module bcd_to_ss7
  import time_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/time_display_engine.sv
// Time display engine: snapshots one of NUM_SRC time sources, converts each
// field to two BCD digits with a sequential shift-add-3 and drives a
// registered seven-segment image with blinking, dashes and leading-zero blank.
//   clk, reset  : clock, asynchronous active-high reset
//   src_fields  : source s field f at [(s*NUM_FIELDS+f)*FIELD_W +: FIELD_W]
//   sel         : source select, sampled only when a snapshot is taken
//   refresh     : request a new conversion (merged into one pending request)
//   blink_tick  : toggles blink phase
//   blink_mask  : per-field blink enable
//   lzb_en      : blank field-0 tens digit when zero
//   busy / upd  : conversion running / one-cycle commit pulse
//   seg_out     : digit d at [8*d +: 8], d=2f tens, d=2f+1 ones
module time_display_engine
  import time_disp_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 7,
  parameter int DP_EN      = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_SRC*NUM_FIELDS*FIELD_W-1:0] src_fields,
  input  logic [$clog2(NUM_SRC)-1:0]          sel,
  input  logic                                refresh,
  input  logic                                blink_tick,
  input  logic [NUM_FIELDS-1:0]               blink_mask,
  input  logic                                lzb_en,
  output logic                                busy,
  output logic                                upd,
  output logic [2*NUM_FIELDS*8-1:0]           seg_out
);

  localparam int FI_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BC_W = $clog2(FIELD_W + 1);

  logic [FIELD_W-1:0] src_arr [NUM_SRC][NUM_FIELDS];

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [FIELD_W-1:0] snap_q [NUM_FIELDS];
  logic [FIELD_W-1:0] snap_d [NUM_FIELDS];
  logic [FI_W-1:0]    fld_q, fld_d;
  logic [BC_W-1:0]    bit_q, bit_d;
  logic [FIELD_W-1:0] shreg_q, shreg_d;
  logic [7:0]         bcd_q, bcd_d;
  logic               dash_q, dash_d;
  logic [7:0]         work_bcd_q [NUM_FIELDS];
  logic [7:0]         work_bcd_d [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] work_dash_q, work_dash_d;
  logic [7:0]         com_bcd_q [NUM_FIELDS];
  logic [7:0]         com_bcd_d [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] com_dash_q, com_dash_d;
  logic               com_valid_q, com_valid_d;
  logic               blink_phase_q, blink_phase_d;
  logic [2*NUM_FIELDS*8-1:0] seg_out_q, seg_out_d;

  logic [7:0]         bcd_adj;
  logic [7:0]         bcd_next;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      for (gj = 0; gj < NUM_FIELDS; gj++) begin : g_fld
        assign src_arr[gi][gj] = src_fields[(gi*NUM_FIELDS+gj)*FIELD_W +: FIELD_W];
      end
    end
  endgenerate

  // One double-dabble step: correct nibbles, then shift the next value bit in.
  assign bcd_adj  = bcd_adjust(bcd_q);
  assign bcd_next = (bcd_adj << 1) | {7'd0, shreg_q[FIELD_W-1]};

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | (refresh && (state_q != IDLE));
    snap_d      = snap_q;
    fld_d       = fld_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    bcd_d       = bcd_q;
    dash_d      = dash_q;
    work_bcd_d  = work_bcd_q;
    work_dash_d = work_dash_q;
    com_bcd_d   = com_bcd_q;
    com_dash_d  = com_dash_q;
    com_valid_d = com_valid_q;
    upd         = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (refresh || pending_q) begin
          state_d   = SNAP;
          pending_d = 1'b0;
        end
      end
      SNAP: begin
        for (int f = 0; f < NUM_FIELDS; f++) snap_d[f] = src_arr[sel][f];
        fld_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = snap_q[fld_q];
        bcd_d   = 8'd0;
        dash_d  = int'(snap_q[fld_q]) > 99;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d   = bcd_next;
        shreg_d = shreg_q << 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BC_W'(FIELD_W - 1)) begin
          // Out-of-range fields still take the full shift time so latency is fixed.
          work_bcd_d[fld_q]  = dash_q ? 8'd0 : bcd_next;
          work_dash_d[fld_q] = dash_q;
          if (fld_q == FI_W'(NUM_FIELDS - 1)) begin
            state_d = COMMIT;
          end else begin
            fld_d   = fld_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      COMMIT: begin
        upd         = 1'b1;
        com_bcd_d   = work_bcd_q;
        com_dash_d  = work_dash_q;
        com_valid_d = 1'b1;
        // A request seen during or at the end of this conversion starts the next one now.
        if (pending_q || refresh) begin
          state_d   = SNAP;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign blink_phase_d = blink_phase_q ^ blink_tick;

  // Output stage works from the next-cycle committed view so that new digits
  // appear the cycle after upd and blink/mask changes appear one cycle later.
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_out
      localparam bit DP_ON = (DP_EN != 0) && (gi < NUM_FIELDS - 1);
      logic [7:0] tens_raw, ones_raw, tens_seg, ones_seg;

      bcd_to_ss7 u_tens (.digit(com_bcd_d[gi][7:4]), .seg(tens_raw));
      bcd_to_ss7 u_ones (.digit(com_bcd_d[gi][3:0]), .seg(ones_raw));

      // Later assignments take priority.
      always_comb begin
        tens_seg = tens_raw;
        ones_seg = DP_ON ? (ones_raw | SEG_DP) : ones_raw;
        if ((gi == 0) && lzb_en && (com_bcd_d[gi][7:4] == 4'd0)) tens_seg = SEG_BLANK;
        if (com_dash_d[gi]) begin
          tens_seg = SEG_DASH;
          ones_seg = SEG_DASH;
        end
        if (blink_phase_d && blink_mask[gi]) begin
          tens_seg = SEG_BLANK;
          ones_seg = SEG_BLANK;
        end
        if (!com_valid_d) begin
          tens_seg = SEG_BLANK;
          ones_seg = SEG_BLANK;
        end
      end

      assign seg_out_d[16*gi +: 16] = {ones_seg, tens_seg};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      fld_q         <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      bcd_q         <= '0;
      dash_q        <= 1'b0;
      work_dash_q   <= '0;
      com_dash_q    <= '0;
      com_valid_q   <= 1'b0;
      blink_phase_q <= 1'b0;
      seg_out_q     <= '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
        snap_q[f]     <= '0;
        work_bcd_q[f] <= '0;
        com_bcd_q[f]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      fld_q         <= fld_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      bcd_q         <= bcd_d;
      dash_q        <= dash_d;
      work_dash_q   <= work_dash_d;
      com_dash_q    <= com_dash_d;
      com_valid_q   <= com_valid_d;
      blink_phase_q <= blink_phase_d;
      seg_out_q     <= seg_out_d;
      for (int f = 0; f < NUM_FIELDS; f++) begin
        snap_q[f]     <= snap_d[f];
        work_bcd_q[f] <= work_bcd_d[f];
        com_bcd_q[f]  <= com_bcd_d[f];
      end
    end
  end

  assign seg_out = seg_out_q;

endmodule

// File: tb/tb_time_display_engine.sv
// Scoreboard bench for time_display_engine at default parameters.
module tb_time_display_engine;

  logic         clk;
  logic         reset;
  logic [111:0] src_fields;
  logic [1:0]   sel;
  logic         refresh;
  logic         blink_tick;
  logic [3:0]   blink_mask;
  logic         lzb_en;
  logic         busy;
  logic         upd;
  logic [63:0]  seg_out;

  time_display_engine dut (
    .clk(clk), .reset(reset), .src_fields(src_fields), .sel(sel),
    .refresh(refresh), .blink_tick(blink_tick), .blink_mask(blink_mask),
    .lzb_en(lzb_en), .busy(busy), .upd(upd), .seg_out(seg_out)
  );

  typedef struct {
    logic [63:0] seg;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   cmp_pending = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] seg7(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Reference display image from field values using decimal arithmetic.
  function automatic logic [63:0] model(input int v0, input int v1, input int v2,
                                        input int v3, input bit lzb);
    int v[4];
    logic [63:0] r;
    logic [7:0] tens, ones;
    v = '{v0, v1, v2, v3};
    r = '0;
    for (int f = 0; f < 4; f++) begin
      if (v[f] > 99) begin
        tens = 8'h40;
        ones = 8'h40;
      end else begin
        tens = seg7(v[f] / 10);
        ones = seg7(v[f] % 10) | ((f < 3) ? 8'h80 : 8'h00);
        if (f == 0 && lzb && (v[f] / 10) == 0) tens = 8'h00;
      end
      r[16*f +: 8]   = tens;
      r[16*f+8 +: 8] = ones;
    end
    return r;
  endfunction

  // Monitor: each upd pops one expectation, checks its cycle, then compares
  // seg_out on the following cycle.
  always @(negedge clk) begin
    if (cmp_pending) begin
      checks++;
      if (seg_out !== cur.seg) begin
        failures++;
        $display("FAIL %s_seg: got %h expected %h", cur.name, seg_out, cur.seg);
      end
      cmp_pending = 0;
    end
    if (upd === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_upd: got upd=1 at cycle %0d expected none", cyc);
      end else begin
        cur = sb.pop_front();
        if (cur.cyc >= 0 && cur.cyc != cyc) begin
          failures++;
          $display("FAIL %s_latency: got upd at cycle %0d expected %0d", cur.name, cyc, cur.cyc);
        end
        $display("upd %s at cycle %0d", cur.name, cyc);
        cmp_pending = 1;
      end
    end
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s ok: %h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input int a, input int b, input int c, input int d);
    src_fields[(s*4+0)*7 +: 7] = 7'(a);
    src_fields[(s*4+1)*7 +: 7] = 7'(b);
    src_fields[(s*4+2)*7 +: 7] = 7'(c);
    src_fields[(s*4+3)*7 +: 7] = 7'(d);
  endtask

  // Pulses refresh for one cycle; t is the cycle in which refresh is high.
  task automatic do_refresh(output int t);
    tick();
    refresh = 1'b1;
    t = cyc;
    tick();
    refresh = 1'b0;
  endtask

  task automatic push(input string name, input logic [63:0] seg, input int c);
    exp_t e;
    e.seg = seg;
    e.cyc = c;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((sb.size() != 0 || cmp_pending) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: got %0d outstanding expected 0", sb.size());
      sb.delete();
      cmp_pending = 0;
    end
  endtask

  task automatic pulse_tick;
    tick();
    blink_tick = 1'b1;
    tick();
    blink_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    logic [63:0] e5;
    logic [63:0] fmask;
    reset = 1'b1;
    src_fields = '0;
    sel = 2'd0;
    refresh = 1'b0;
    blink_tick = 1'b0;
    blink_mask = 4'd0;
    lzb_en = 1'b0;
    fmask = 64'hFFFF_FFFF_0000_FFFF;

    repeat (3) @(negedge clk);
    check_eq("reset_seg", seg_out, 64'd0);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_upd", {63'd0, upd}, 64'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // 1: default conversion and latency
    set_src(2, 12, 34, 56, 78);
    sel = 2'd2;
    tick();
    refresh = 1'b1;
    t = cyc;
    push("t1", 64'h7F07_FD6D_E64F_DB06, t + 34);
    tick();
    refresh = 1'b0;
    @(negedge clk);
    check_eq("t1_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    repeat (2) tick();
    check_eq("t1_idle_busy", {63'd0, busy}, 64'd0);

    // 2: out-of-range and boundary values
    set_src(0, 100, 99, 0, 127);
    sel = 2'd0;
    tick();
    refresh = 1'b1;
    t = cyc;
    push("t2", 64'h4040_BF3F_EF6F_4040, t + 34);
    tick();
    refresh = 1'b0;
    wait_idle();

    // 3: three requests while busy merge into one extra conversion
    set_src(1, 1, 2, 3, 4);
    set_src(3, 10, 20, 30, 40);
    sel = 2'd1;
    tick();
    refresh = 1'b1;
    t = cyc;
    push("t3a", model(1, 2, 3, 4, 0), t + 34);
    push("t3b", model(10, 20, 30, 40, 0), t + 68);
    tick();
    refresh = 1'b0;
    repeat (4) tick();
    sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      tick();
    end
    wait_idle();
    repeat (40) tick();

    // 4: source changes mid-conversion are not seen
    set_src(3, 1, 2, 3, 4);
    sel = 2'd3;
    do_refresh(t);
    push("t4", model(1, 2, 3, 4, 0), t + 34);
    repeat (4) tick();
    sel = 2'd0;
    set_src(3, 9, 9, 9, 9);
    repeat (15) tick();
    set_src(3, 88, 77, 66, 55);
    wait_idle();

    // 5: leading-zero blank and field blinking
    set_src(2, 5, 34, 56, 78);
    sel = 2'd2;
    lzb_en = 1'b1;
    e5 = model(5, 34, 56, 78, 1);
    do_refresh(t);
    push("t5", e5, t + 34);
    wait_idle();
    tick();
    blink_mask = 4'b0010;
    tick();
    @(negedge clk);
    check_eq("t5_mask_phase0", seg_out, e5);
    pulse_tick();
    check_eq("t5_blink_on", seg_out, e5 & fmask);
    pulse_tick();
    check_eq("t5_blink_off", seg_out, e5);
    pulse_tick();
    check_eq("t5_blink_on2", seg_out, e5 & fmask);
    tick();
    blink_mask = 4'b0000;
    tick();
    @(negedge clk);
    check_eq("t5_mask_clear", seg_out, e5);
    pulse_tick();
    tick();
    lzb_en = 1'b0;
    tick();
    @(negedge clk);
    check_eq("t5_lzb_off", seg_out, (e5 & ~64'hFF) | 64'h3F);

    // 6: reset mid-conversion with a pending request
    set_src(0, 11, 22, 33, 44);
    sel = 2'd0;
    do_refresh(t);
    repeat (3) tick();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_eq("t6_reset_seg", seg_out, 64'd0);
    check_eq("t6_reset_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check_eq("t6_no_pending_busy", {63'd0, busy}, 64'd0);
    do_refresh(t);
    push("t6", model(11, 22, 33, 44, 0), t + 34);
    wait_idle();
    repeat (3) tick();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
